// File: rtl/axis_insert_arbiter.sv
// Packet-level round-robin arbiter in front of axi_stream_insert_header.
// One source owns both header and stream channels until its last beat.
module axis_insert_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC      = 4,
  parameter int SRC_ID_WD    = $clog2(NUM_SRC)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SRC-1:0]                s_valid,
  input  logic [NUM_SRC*DATA_WD-1:0]        s_data,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep,
  input  logic [NUM_SRC-1:0]                s_last,
  output logic [NUM_SRC-1:0]                s_ready,
  input  logic [NUM_SRC-1:0]                h_valid,
  input  logic [NUM_SRC*DATA_WD-1:0]        h_data,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   h_keep,
  input  logic [NUM_SRC*BYTE_CNT_WD-1:0]    h_cnt,
  output logic [NUM_SRC-1:0]                h_ready,
  output logic                              valid_in,
  output logic [DATA_WD-1:0]                data_in,
  output logic [DATA_BYTE_WD-1:0]           keep_in,
  output logic                              last_in,
  input  logic                              ready_in,
  output logic                              valid_insert,
  output logic [DATA_WD-1:0]                data_insert,
  output logic [DATA_BYTE_WD-1:0]           keep_insert,
  output logic [BYTE_CNT_WD-1:0]            byte_insert_cnt,
  input  logic                              ready_insert,
  output logic [SRC_ID_WD-1:0]              grant_id,
  output logic                              busy,
  output logic [15:0]                       pkt_beats
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BODY
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [SRC_ID_WD-1:0] ptr;
  logic [SRC_ID_WD-1:0] pick;
  logic [NUM_SRC-1:0]   req;
  logic                 any_req;
  logic                 s_hs;
  logic                 h_hs;
  logic                 s_end;
  logic [15:0]          cnt;
  logic [15:0]          cnt_inc;

  // Scan ptr+1, ptr+2, ... so the last winner has lowest priority.
  function automatic logic [SRC_ID_WD-1:0] rr_pick(
    input logic [NUM_SRC-1:0]   r,
    input logic [SRC_ID_WD-1:0] p
  );
    logic [SRC_ID_WD-1:0] sel;
    logic [SRC_ID_WD-1:0] idx;
    logic                 hit;
    sel = '0;
    hit = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = SRC_ID_WD'((int'(p) + k) % NUM_SRC);
      if (!hit && r[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
    return sel;
  endfunction

  assign req     = h_valid & s_valid;
  assign any_req = |req;
  assign pick    = rr_pick(req, ptr);
  assign s_hs    = valid_in & ready_in;
  assign h_hs    = valid_insert & ready_insert;
  assign s_end   = s_hs & last_in;
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  always_comb begin
    valid_in        = 1'b0;
    data_in         = '0;
    keep_in         = '0;
    last_in         = 1'b0;
    valid_insert    = 1'b0;
    data_insert     = '0;
    keep_insert     = '0;
    byte_insert_cnt = '0;
    s_ready         = '0;
    h_ready         = '0;
    if (state == HDR || state == BODY) begin
      valid_in          = s_valid[grant_id];
      data_in           = s_data[grant_id*DATA_WD +: DATA_WD];
      keep_in           = s_keep[grant_id*DATA_BYTE_WD +: DATA_BYTE_WD];
      last_in           = s_last[grant_id];
      s_ready[grant_id] = ready_in;
    end
    if (state == HDR) begin
      valid_insert      = h_valid[grant_id];
      data_insert       = h_data[grant_id*DATA_WD +: DATA_WD];
      keep_insert       = h_keep[grant_id*DATA_BYTE_WD +: DATA_BYTE_WD];
      byte_insert_cnt   = h_cnt[grant_id*BYTE_CNT_WD +: BYTE_CNT_WD];
      h_ready[grant_id] = ready_insert;
    end
  end

  // A one-beat packet can finish in HDR; last wins over the header step.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (any_req) state_nxt = HDR;
      HDR: begin
        if (s_end)     state_nxt = IDLE;
        else if (h_hs) state_nxt = BODY;
      end
      BODY: if (s_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= SRC_ID_WD'(NUM_SRC - 1);
      grant_id  <= '0;
      busy      <= 1'b0;
      pkt_beats <= '0;
      cnt       <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        grant_id <= pick;
        busy     <= 1'b1;
        cnt      <= '0;
      end
      if (s_hs) begin
        cnt <= cnt_inc;
        if (last_in) begin
          pkt_beats <= cnt_inc;
          ptr       <= grant_id;
          busy      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/axis_insert_arbiter.md
# axis_insert_arbiter

Packet-level round-robin arbiter that lets NUM_SRC AXI-Stream sources, each with its own header channel, share one `axi_stream_insert_header` datapath. Selects one source, connects its header channel and its stream channel to the inserter, and holds the grant until that source's `last` beat is accepted. Sits directly upstream of the inserter; the inserter's output is untouched.

## Interface
- DATA_WD, 32, stream/header data width in bits
- DATA_BYTE_WD, DATA_WD/8, keep width
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), header byte-count width
- NUM_SRC, 4, number of sources (2..16)
- SRC_ID_WD, $clog2(NUM_SRC), grant index width

Ports (vectors packed, source i at slice i):
- clk  in  1  clock; everything on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  NUM_SRC  per-source stream valid
- s_data  in  NUM_SRC*DATA_WD  per-source stream data
- s_keep  in  NUM_SRC*DATA_BYTE_WD  per-source stream keep
- s_last  in  NUM_SRC  per-source stream last
- s_ready  out  NUM_SRC  per-source stream ready
- h_valid  in  NUM_SRC  per-source header valid
- h_data  in  NUM_SRC*DATA_WD  per-source header data
- h_keep  in  NUM_SRC*DATA_BYTE_WD  per-source header keep
- h_cnt  in  NUM_SRC*BYTE_CNT_WD  per-source byte_insert_cnt
- h_ready  out  NUM_SRC  per-source header ready
- valid_in, data_in, keep_in, last_in  out  1/DATA_WD/DATA_BYTE_WD/1  stream to inserter
- ready_in  in  1  inserter stream ready
- valid_insert, data_insert, keep_insert, byte_insert_cnt  out  1/DATA_WD/DATA_BYTE_WD/BYTE_CNT_WD  header to inserter
- ready_insert  in  1  inserter header ready
- grant_id  out  SRC_ID_WD  current/last granted source (registered)
- busy  out  1  1 while a packet is granted (registered)
- pkt_beats  out  16  stream-beat count of last completed packet, saturating at 16'hFFFF

## Operation
- State machine: IDLE, HDR (header not yet accepted), BODY (header accepted, stream in progress).
- Request: req[i] = h_valid[i] & s_valid[i]. Header-only or stream-only sources never request.
- IDLE: if any req, pick first set req[i] scanning ptr+1, ptr+2, … modulo NUM_SRC; register grant_id=i, busy=1, go HDR. No req: stay.
- HDR: header channel and stream channel of grant_id muxed to inserter; h_ready[g]=ready_insert, s_ready[g]=ready_in; all other h_ready/s_ready=0. Header handshake (valid_insert & ready_insert) -> BODY.
- BODY: valid_insert forced 0, h_ready all 0; stream channel of grant_id still muxed through.
- Stream handshake with last_in=1 in HDR or BODY -> IDLE, ptr<=grant_id, busy<=0. If last handshake and header handshake coincide (one-beat packet), go IDLE.
- Any state outside HDR/BODY: all out valids 0, all h_ready/s_ready 0; data/keep/cnt outputs driven 0.
- Beat counter: cleared on entry to HDR, +1 per stream handshake, saturating; copied to pkt_beats on the last handshake.
- Sources obey AXI: valid held until handshake; arbiter does not re-evaluate grant mid-packet.

## Timing
- Reset (async assert, sync release): state IDLE, ptr=NUM_SRC-1 (source 0 first priority), grant_id=0, busy=0, pkt_beats=0, counter 0; all out valids and readys 0.
- Arbitration latency: req seen in IDLE at cycle t -> busy=1 and valid_in/valid_insert=1 at t+1.
- Mux path is combinational (source -> inserter and inserter ready -> source), zero added latency in HDR/BODY.
- Packet gap: last handshake at t -> IDLE at t+1 -> next grant at t+2 (one idle cycle minimum).
- Reset mid-packet: state drops to IDLE immediately; partial packet abandoned; no ready asserted while rst_n=0.

## Test plan
- Single source 0, 3-beat packet, header cnt=1, ready_in=ready_insert=1 -> grant_id=0, busy 1 for 3 cycles, s_ready[0] 3 beats, pkt_beats=3, busy 0 after.
- Sources 1 and 3 request together from reset, 2-beat packets each -> source 1 granted first, source 3 at 2 cycles after source 1's last; then new req on 1 and 3 -> 1 again (ptr=3).
- Source 2 h_valid=1, s_valid=0 for 10 cycles -> no grant, busy=0; raise s_valid -> grant at next cycle.
- One-beat packet (s_last=1 on first beat) with header -> header and last handshake same cycle, state IDLE next cycle, pkt_beats=1.
- ready_in toggling 1,0,1,0 in BODY on 4-beat packet -> only source's s_ready follows ready_in, other s_ready=0, data_in stable when ready_in=0, pkt_beats=4.
- rst_n low in BODY beat 2 -> busy=0, all readys 0 same cycle; after release, a fresh request is granted starting from source 0 priority.
